// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package fetch_stage_pkg;

    // Default PC after reset: MIPS user text segment base.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // NOP encoding (sll $0,$0,0); presented to decode whenever IF/ID is empty.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // RUN:  normal fetching.
    // DROP: a redirect arrived while a fetch was outstanding, so that response
    //       must be consumed and discarded before fetching the target.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } fetch_state_t;

    // One fetched instruction together with the PC+4 that decode needs.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus_four;
    } fetch_entry_t;

    // Sequential PC increment; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are word addresses; the low two bits are ignored.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction fetched while decode is stalled.
// Latency: push visible on outputs the cycle after; pop frees the slot the cycle after.
// Backpressure: o_full tells the owner to stop requesting; push+pop in one cycle reloads.
//
// Ports:
//   i_clock, i_reset               clock, synchronous active-high reset
//   i_push / i_pop / i_clear       write, consume, discard (clear has priority)
//   i_instruction, i_pc_plus_four  entry to store on push
//   o_full                         slot occupied
//   o_instruction, o_pc_plus_four  stored entry (valid while o_full)
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_clear,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc_plus_four,
    output logic        o_full,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_plus_four
);

    logic         r_full;
    fetch_entry_t r_entry;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_push) begin
            // Push with a simultaneous pop replaces the drained entry,
            // so the slot stays occupied.
            r_full               <= 1'b1;
            r_entry.instruction  <= i_instruction;
            r_entry.pc_plus_four <= i_pc_plus_four;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full         = r_full;
    assign o_instruction  = r_entry.instruction;
    assign o_pc_plus_four = r_entry.pc_plus_four;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, the IF/ID register and redirect squashing.
// Latency: imem transfer at N -> IF/ID at N+1; redirect at N -> target on imem_addr at N+1 (or after a drop).
// Backpressure: decode stall parks one fetch in a skid slot, then drops imem_req until unstalled.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_stall                   hazard unit: hold IF/ID
//   i_pc_src, i_jump_address  redirect request and target from decode
//   o_imem_req, o_imem_addr   fetch request and word address
//   i_imem_ready, i_imem_rdata  memory response for o_imem_addr this cycle
//   o_if_id_valid, o_if_id_instruction, o_if_id_pc_plus_four  IF/ID register to decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_pc_src,
    input  logic [31:0] i_jump_address,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_instruction,
    output logic [31:0] o_if_id_pc_plus_four
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_target;
    logic [31:0]  w_target_nxt;

    logic         r_if_id_valid;
    logic [31:0]  r_if_id_instruction;
    logic [31:0]  r_if_id_pc_plus_four;
    logic         w_if_id_valid_nxt;
    logic [31:0]  w_if_id_instruction_nxt;
    logic [31:0]  w_if_id_pc_plus_four_nxt;

    logic         w_skid_full;
    logic [31:0]  w_skid_instruction;
    logic [31:0]  w_skid_pc_plus_four;
    logic         w_skid_push;
    logic         w_skid_pop;
    logic         w_skid_clear;

    logic         w_imem_req;
    logic         w_transfer;
    logic         w_redirect;
    logic [31:0]  w_pc_plus_four;
    logic [31:0]  w_jump_target;

    // A stalled decode cannot accept a redirect; it re-presents it later.
    assign w_redirect     = i_pc_src && !i_stall;
    assign w_pc_plus_four = next_seq_pc(r_pc);
    assign w_jump_target  = align_word(i_jump_address);

    // Requests stop only while the skid slot is occupied and decode is still
    // stalled. When the stall lifts the slot drains into IF/ID this cycle, so
    // a new fetch may land in the slot behind it.
    assign w_imem_req = (r_state == ST_DROP) || !w_skid_full || !i_stall;
    assign w_transfer = w_imem_req && i_imem_ready;

    fetch_skid_buffer u_skid (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_push         (w_skid_push),
        .i_pop          (w_skid_pop),
        .i_clear        (w_skid_clear),
        .i_instruction  (i_imem_rdata),
        .i_pc_plus_four (w_pc_plus_four),
        .o_full         (w_skid_full),
        .o_instruction  (w_skid_instruction),
        .o_pc_plus_four (w_skid_pc_plus_four)
    );

    always_comb begin
        w_state_nxt              = r_state;
        w_pc_nxt                 = r_pc;
        w_target_nxt             = r_target;
        w_if_id_valid_nxt        = r_if_id_valid;
        w_if_id_instruction_nxt  = r_if_id_instruction;
        w_if_id_pc_plus_four_nxt = r_if_id_pc_plus_four;
        w_skid_push              = 1'b0;
        w_skid_pop               = 1'b0;
        w_skid_clear             = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    // Squash everything younger than the redirecting instruction.
                    w_if_id_valid_nxt = 1'b0;
                    w_skid_clear      = 1'b1;
                    if (w_imem_req && !i_imem_ready) begin
                        // Address must stay stable until memory answers,
                        // so park the target and throw the response away.
                        w_target_nxt = w_jump_target;
                        w_state_nxt  = ST_DROP;
                    end else begin
                        w_pc_nxt = w_jump_target;
                    end
                end else begin
                    if (w_transfer) begin
                        w_pc_nxt = w_pc_plus_four;
                    end

                    if (i_stall) begin
                        // IF/ID holds; a completed fetch goes to the slot.
                        if (w_transfer) begin
                            w_skid_push = 1'b1;
                        end
                    end else if (w_skid_full) begin
                        // Oldest instruction is in the slot: it goes first.
                        w_if_id_valid_nxt        = 1'b1;
                        w_if_id_instruction_nxt  = w_skid_instruction;
                        w_if_id_pc_plus_four_nxt = w_skid_pc_plus_four;
                        w_skid_pop               = 1'b1;
                        if (w_transfer) begin
                            w_skid_push = 1'b1;
                        end
                    end else if (w_transfer) begin
                        w_if_id_valid_nxt        = 1'b1;
                        w_if_id_instruction_nxt  = i_imem_rdata;
                        w_if_id_pc_plus_four_nxt = w_pc_plus_four;
                    end else begin
                        w_if_id_valid_nxt = 1'b0;
                    end
                end
            end

            ST_DROP: begin
                w_if_id_valid_nxt = 1'b0;
                // A newer redirect supersedes the parked one, including in the
                // same cycle the discarded response arrives.
                if (w_redirect) begin
                    w_target_nxt = w_jump_target;
                end
                if (i_imem_ready) begin
                    w_pc_nxt    = w_redirect ? w_jump_target : r_target;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state              <= ST_RUN;
            r_pc                 <= RESET_PC;
            r_target             <= RESET_PC;
            r_if_id_valid        <= 1'b0;
            r_if_id_instruction  <= NOP_INSTR;
            r_if_id_pc_plus_four <= '0;
        end else begin
            r_state              <= w_state_nxt;
            r_pc                 <= w_pc_nxt;
            r_target             <= w_target_nxt;
            r_if_id_valid        <= w_if_id_valid_nxt;
            r_if_id_instruction  <= w_if_id_instruction_nxt;
            r_if_id_pc_plus_four <= w_if_id_pc_plus_four_nxt;
        end
    end

    assign o_imem_req           = w_imem_req;
    assign o_imem_addr          = r_pc;
    assign o_if_id_valid        = r_if_id_valid;
    // Squashed or empty slots must look like a NOP to the decoder.
    assign o_if_id_instruction  = r_if_id_valid ? r_if_id_instruction : NOP_INSTR;
    assign o_if_id_pc_plus_four = r_if_id_pc_plus_four;

endmodule
